// File: rtl/mux_arb_reg.sv
// -----------------------------------------------------------------------------
// mux_arb_reg
//
// Purpose:
//   NCH-channel, W-bit select/arbitrate multiplexer with a valid/ready
//   handshake on every input and on the output. One output register stage.
//
//   Modes:
//   - mode=0: fixed select. The channel is chosen by sel.
//   - mode=1: round-robin arbitration among the valid channels.
//
// Optional feature:
//   Define MUX_ARB_REG_PARITY_EN to add out_par. It is the even parity
//   (XOR-reduction) of the word held in out_data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    NCH*W   channel i is in_data[i*W +: W]
//   in_valid   NCH     per-channel valid
//   in_ready   NCH     per-channel ready (combinational)
//   mode       1       0 = fixed select, 1 = round-robin
//   sel        SELW    channel index used when mode=0
//   out_data   W       registered selected word
//   out_chan   SELW    registered index of the channel that sourced out_data
//   out_valid  1       registered output valid
//   out_ready  1       downstream ready
//   out_par    1       (MUX_ARB_REG_PARITY_EN only) registered parity
// -----------------------------------------------------------------------------
module mux_arb_reg #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_ARB_REG_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [W-1:0]    ch_data [NCH];
  logic [NCH-1:0]  grant;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_any;
  logic [SELW-1:0] scan_idx;
  int              scan_sum;
  logic            load_en;

  logic [W-1:0]    out_data_reg;
  logic [SELW-1:0] out_chan_reg;
  logic            out_valid_reg;
  logic [SELW-1:0] rr_ptr_reg;

  // Unpack the flat input bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // The output register can accept a new word when it is empty or draining.
  assign load_en = !out_valid_reg || out_ready;

  // Grant decision. The result is at most one-hot.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    scan_sum = 0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so no grant is given.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SELW'(i);
          gnt_any  = 1'b1;
        end
      end
    end else begin
      // Scan from the farthest offset back down to rr_ptr. The last hit
      // overwrites the others, so the channel nearest rr_ptr (moving upward
      // and wrapping) wins.
      for (int k = NCH - 1; k >= 0; k--) begin
        scan_sum = int'(rr_ptr_reg) + k;
        if (scan_sum >= NCH) begin
          scan_sum = scan_sum - NCH;
        end
        scan_idx = SELW'(scan_sum);
        if (in_valid[scan_idx]) begin
          grant           = '0;
          grant[scan_idx] = 1'b1;
          gnt_idx         = scan_idx;
          gnt_any         = 1'b1;
        end
      end
    end
  end

  assign in_ready = grant & {NCH{rst_n && load_en}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_data_reg  <= ch_data[gnt_idx];
        out_chan_reg  <= gnt_idx;
        out_valid_reg <= 1'b1;
        // Only round-robin grants move the pointer.
        if (mode) begin
          rr_ptr_reg <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        // Nothing to load: the old word drained, so mark the stage empty.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

`ifdef MUX_ARB_REG_PARITY_EN
  logic out_par_reg;

  // Parity is loaded and held together with out_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_reg <= 1'b0;
    end else if (load_en && gnt_any) begin
      out_par_reg <= ^ch_data[gnt_idx];
    end
  end

  assign out_par = out_par_reg;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_reg
//
// Scoreboard bench for mux_arb_reg (NCH=4, W=8, SELW=2).
//
// - The stimulus task drives one cycle of inputs and checks in_ready.
// - When a handshake is expected, the task pushes the hand-computed output
//   word onto a queue.
// - A separate monitor pops that queue and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_mux_arb_reg;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] chan;
    logic       par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef MUX_ARB_REG_PARITY_EN
  logic        out_par;
`endif

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] D_BASE = 32'h44332211;
  localparam logic [31:0] D_ALT  = 32'hA4A3A2A1;

  always #5 clk = ~clk;

  mux_arb_reg #(.NCH(4), .W(8), .SELW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_ARB_REG_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after posedge, then check in_ready at negedge.
  // A nonzero exp_rdy means a handshake is expected on the coming edge.
  task automatic step(input logic rst, input logic md, input logic [1:0] s,
                      input logic [3:0] v, input logic [31:0] d, input logic ordy,
                      input logic [3:0] exp_rdy, input logic [7:0] ed,
                      input logic [1:0] ec, input logic ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    mode      = md;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    $display("step rst_n=%0b mode=%0b sel=%0d in_valid=%b out_ready=%0b in_ready=%b",
             rst, md, s, v, ordy, in_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e.data = ed;
      e.chan = ec;
      e.par  = ep;
      sbq.push_back(e);
    end
  endtask

  // Monitor: a transfer completes on the next edge whenever valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data=0x%0h chan=%0d, required none",
                 out_data, out_chan);
      end else begin
        e = sbq.pop_front();
        $display("xfer data=0x%0h chan=%0d (expected 0x%0h chan %0d)",
                 out_data, out_chan, e.data, e.chan);
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_chan", 64'(out_chan), 64'(e.chan));
`ifdef MUX_ARB_REG_PARITY_EN
        chk("out_par", 64'(out_par), 64'(e.par));
`endif
      end
    end
  end

  initial begin
    // 1. Reset with every input valid.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'h00);
      chk("rst_out_chan", 64'(out_chan), 64'd0);
    end

    // 3. Round-robin rotation straight out of reset: 0,1,2,3,0,1.
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b0);

    // 2. Fixed select of channel 2. Then sel=2 with channel 2 idle gives no grant.
    step(1'b1, 1'b0, 2'd2, 4'b1111, D_BASE, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'b1011, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("empty_out_valid", 64'(out_valid), 64'd0);

    // The fixed grant left rr_ptr at 2, so round-robin resumes at channel 2.
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b0);

    // 4. Backpressure. Load 0x22 from channel 1, then stall while the inputs change.
    step(1'b1, 1'b0, 2'd1, 4'b0010, D_BASE, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_ALT, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("bp_data", 64'(out_data), 64'h22);
    chk("bp_chan", 64'(out_chan), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    step(1'b1, 1'b0, 2'd3, 4'b1000, D_ALT, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("bp_data", 64'(out_data), 64'h22);
    chk("bp_chan", 64'(out_chan), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    step(1'b1, 1'b1, 2'd0, 4'b0101, D_ALT, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("bp_data", 64'(out_data), 64'h22);
    chk("bp_chan", 64'(out_chan), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    // Release: 0x22 drains and channel 3 (rr_ptr=3) loads on the same edge.
    step(1'b1, 1'b1, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b0);

    // 5. Sparse round-robin from rr_ptr=0: channel 1, then 3, then drain.
    step(1'b1, 1'b1, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    // rr_ptr wrapped to 0, so channel 1 wins again.
    step(1'b1, 1'b1, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b0);

    // 6. Parity words: 0xA7 has odd weight, 0x3C has even weight.
    step(1'b1, 1'b0, 2'd0, 4'b0001, 32'h000000A7, 1'b1, 4'b0001, 8'hA7, 2'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 4'b0001, 32'h0000003C, 1'b1, 4'b0001, 8'h3C, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);

    // Reset mid-transfer discards the held word.
    step(1'b1, 1'b0, 2'd0, 4'b0001, 32'h00000055, 1'b1, 4'b0001, 8'h55, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b1111, D_BASE, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    if (sbq.size() != 0) begin
      void'(sbq.pop_back());
    end
    step(1'b1, 1'b0, 2'd0, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'h00);
    chk("midrst_out_chan", 64'(out_chan), 64'd0);

    step(1'b1, 1'b0, 2'd0, 4'b0000, D_BASE, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-channel, W-bit select/arbitrate multiplexer with valid/ready handshake on every input and on the output.
- Single registered output stage.
- Replaces the fixed 1-bit, 4:1 combinational select muxes in datapaths that need backpressure and fair sharing.
- Two modes:
  - Fixed-select: the channel is chosen by a `sel` port.
  - Round-robin: the block arbitrates among valid channels.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 8, data width per channel (1..64).
- SELW, 2, width of select/channel index; must equal clog2(NCH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_data  input  NCH*W  channel i occupies bits [i*W +: W].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed-select mode.
- out_data  output  W  registered selected data.
- out_chan  output  SELW  registered index of the channel that sourced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is all-zero while rst_n=0. Reset mid-transfer discards the held word; no handshake completes on that edge.
- load_en = !out_valid || out_ready. A transfer on the output occurs when out_valid && out_ready.
- Grant (combinational, at most one-hot):
  - mode=0: grant[sel]=1 iff in_valid[sel]; all other bits 0. If sel >= NCH, no grant.
  - mode=1: first i with in_valid[i]=1, scanning from rr_ptr upward and wrapping at NCH-1 to 0.
- in_ready[i] = rst_n && load_en && grant[i]. A handshake on channel i requires in_valid[i] && in_ready[i].
- On an input handshake at posedge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - if mode=1: rr_ptr <= (g==NCH-1) ? 0 : g+1
- If load_en=1 and there is no grant: out_valid <= 0; out_data and out_chan hold.
- If load_en=0: all output registers hold. out_data must be stable while out_valid && !out_ready.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word/cycle with out_ready held at 1. Simultaneous output drain and input load in the same cycle is supported (no bubble).
- rr_ptr is updated only by round-robin grants. A fixed-select grant leaves rr_ptr unchanged.
- Mode or sel changes take effect on the next grant decision. A word already held is unaffected.
- Fairness: in mode=1 with all channels continuously valid and out_ready=1, grants rotate 0,1,...,NCH-1,0,... Each channel waits at most NCH-1 grants.

Optional Feature:
- Macro: MUX_ARB_REG_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit, registered) = XOR-reduction of the word loaded into out_data (even parity). Reset value 0.
  - out_par updates and holds exactly as out_data does.
- Undefined: port out_par does not exist; no parity logic is synthesised.

Test Plan:
1. Reset: drive rst_n=0 for 2 clk with all in_valid=1 -> out_valid=0, out_data=0x00, out_chan=0, in_ready=4'b0000.
2. Fixed select: mode=0, sel=2, in_valid=4'b1111, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0x33, out_chan=2, out_valid=1.
3. Round-robin rotation: mode=1, all valid, out_ready=1 for 6 cycles after reset -> out_chan sequence 0,1,2,3,0,1 with matching data.
4. Backpressure: a word is loaded (0x22, chan 1) and out_ready=0 for 3 cycles while inputs change -> out_data=0x22, out_chan=1, out_valid=1 held; in_ready=0 throughout. out_ready=1 -> next word loads the same cycle the 0x22 transfer completes.
5. Sparse round-robin: mode=1, rr_ptr=0, in_valid=4'b1010 -> grant chan 1, rr_ptr=2. Next cycle grant chan 3, rr_ptr=0. Then in_valid=0 -> out_valid drops to 0 after the drain.
6. With MUX_ARB_REG_PARITY_EN: load in_data 0xA7 -> out_par=1. Load 0x3C -> out_par=0. Without the macro the bench compiles with no out_par port.
